// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, an optional hardwired zero register and a sequential bulk-clear engine.
// Define REGFILE_BYPASS_EN for write-first same-cycle forwarding; otherwise reads return the pre-write value.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_RD-1:0]          i_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_valid,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_clear_req,
  output logic                       o_busy
);

  // state   | meaning
  // S_IDLE  | normal operation, writes accepted
  // S_CLEAR | zeroing one entry per cycle at r_ptr, writes dropped
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam int DEPTH = 1 << ADDR_W;

  state_t              r_state;
  logic [ADDR_W:0]     r_ptr;
  logic                r_busy;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rd_data [NUM_RD];
  logic [NUM_RD-1:0]   r_rd_valid;

  logic [ADDR_W-1:0]   w_rd_addr [NUM_RD];
  logic [DATA_W-1:0]   w_rd_next [NUM_RD];
  logic                w_wr_zero;
  logic                w_wr_do;

  assign w_wr_zero = (ZERO_REG != 0) && (i_wr_addr == '0);
  assign w_wr_do   = i_wr_en && !r_busy && !w_wr_zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_clear_req) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_ptr == (ADDR_W+1)'(DEPTH-1)) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + (ADDR_W+1)'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ptr   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The clear engine owns the array while busy; w_wr_do is already gated by r_busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_ptr[ADDR_W-1:0]] <= '0;
    end else if (w_wr_do) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    assign w_rd_addr[g]                    = i_rd_addr[g*ADDR_W +: ADDR_W];
    assign o_rd_data[g*DATA_W +: DATA_W]   = r_rd_data[g];
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd_next[p] = r_mem[w_rd_addr[p]];
      if ((ZERO_REG != 0) && (w_rd_addr[p] == '0)) w_rd_next[p] = '0;
`ifdef REGFILE_BYPASS_EN
      if (w_wr_do && (w_rd_addr[p] == i_wr_addr)) w_rd_next[p] = i_wr_data;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int p = 0; p < NUM_RD; p++) r_rd_data[p] <= '0;
      r_rd_valid <= '0;
    end else begin
      r_rd_valid <= i_rd_en;
      for (int p = 0; p < NUM_RD; p++) begin
        if (i_rd_en[p]) r_rd_data[p] <= w_rd_next[p];
      end
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: instance a has ZERO_REG=1, instance b has ZERO_REG=0, both driven identically.
// Expected read data is queued at issue time and popped by a monitor whenever a port flags valid.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clear_req;

  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_valid, b_rd_valid;
  logic        a_busy, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q [4][$];

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] HAZ_R8  = 32'h0000_0014;
  localparam logic [31:0] HAZ_R0B = 32'h0000_0077;
`else
  localparam logic [31:0] HAZ_R8  = 32'h0000_000A;
  localparam logic [31:0] HAZ_R0B = 32'hDEAD_BEEF;
`endif

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_clear_req(clear_req), .o_busy(a_busy)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_clear_req(clear_req), .o_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] en, input logic [4:0] ad0, input logic [4:0] ad1,
                    input logic [31:0] ea0, input logic [31:0] ea1,
                    input logic [31:0] eb0, input logic [31:0] eb1);
    rd_en   = en;
    rd_addr = {ad1, ad0};
    if (en[0]) begin q[0].push_back(ea0); q[2].push_back(eb0); end
    if (en[1]) begin q[1].push_back(ea1); q[3].push_back(eb1); end
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic busy_count(output int n);
    n = 0;
    while (a_busy && n < 100) begin
      tick;
      n++;
    end
  endtask

  always @(negedge clk) begin
    logic [3:0]  mon_v;
    logic [31:0] mon_d [4];
    logic [31:0] exp;
    if (rst_n) begin
      mon_v    = {b_rd_valid, a_rd_valid};
      mon_d[0] = a_rd_data[31:0];
      mon_d[1] = a_rd_data[63:32];
      mon_d[2] = b_rd_data[31:0];
      mon_d[3] = b_rd_data[63:32];
      for (int k = 0; k < 4; k++) begin
        if (mon_v[k]) begin
          n_tests++;
          if (q[k].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid stream %0d: got %h with nothing queued", k, mon_d[k]);
          end else begin
            exp = q[k].pop_front();
            if (mon_d[k] !== exp) begin
              n_fail++;
              $display("FAIL rd_data stream %0d: got %h expected %h", k, mon_d[k], exp);
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",  {62'd0, b_busy, a_busy}, 64'd0);
    chk("reset_valid", {60'd0, b_rd_valid, a_rd_valid}, 64'd0);
    chk("reset_data",  a_rd_data, 64'd0);
    rst_n = 1'b1;

    rd(2'b11, 5'd7, 5'd31, 0, 0, 0, 0);
    tick;
    rd_en = '0;

    wr(1, 5'd1, 32'hAAAA_AAAA); tick;
    wr(1, 5'd2, 32'hBBBB_BBBB); tick;
    wr_en = 0;
    rd(2'b11, 5'd1, 5'd2, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    tick;
    rd_en = '0;
    tick;
    chk("hold_valid", {62'd0, a_rd_valid}, 64'd0);
    chk("hold_data",  a_rd_data, {32'hBBBB_BBBB, 32'hAAAA_AAAA});

    wr(1, 5'd0, 32'hDEAD_BEEF); tick;
    wr_en = 0;
    rd(2'b11, 5'd0, 5'd0, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tick;
    rd_en = '0;

    wr(1, 5'd8, 32'h0000_000A); tick;
    wr(1, 5'd8, 32'h0000_0014);
    rd(2'b11, 5'd8, 5'd1, HAZ_R8, 32'hAAAA_AAAA, HAZ_R8, 32'hAAAA_AAAA);
    tick;
    wr_en = 0;
    rd(2'b11, 5'd8, 5'd8, 32'h14, 32'h14, 32'h14, 32'h14);
    tick;

    wr(1, 5'd0, 32'h0000_0077);
    rd(2'b01, 5'd0, 5'd0, 0, 0, HAZ_R0B, 0);
    tick;
    wr_en = 0;
    rd(2'b01, 5'd0, 5'd0, 0, 0, 32'h77, 0);
    tick;
    rd_en = '0;

    wr(1, 5'd16, 32'd2); tick;
    wr(1, 5'd17, 32'd2); tick;
    wr_en = 0;
    clear_req = 1; tick;
    clear_req = 0;
    chk("busy_rise", {63'd0, a_busy}, 64'd1);
    n = 0;
    while (a_busy && n < 100) begin
      wr_en = 0; rd_en = '0; clear_req = 0;
      if (n == 5)  rd(2'b01, 5'd16, 5'd0, 32'd2, 0, 32'd2, 0);
      if (n == 10) clear_req = 1;
      if (n == 25) begin
        rd(2'b11, 5'd16, 5'd0, 0, 0, 0, 0);
        wr(1, 5'd17, 32'd99);
      end
      tick;
      n++;
    end
    wr_en = 0; rd_en = '0; clear_req = 0;
    chk("busy_cycles", 64'(n), 64'd32);
    chk("busy_b_fall", {63'd0, b_busy}, 64'd0);
    rd(2'b11, 5'd17, 5'd16, 0, 0, 0, 0);
    tick;
    rd_en = '0;

    wr(1, 5'd30, 32'h0000_0055); tick;
    wr_en = 0;
    clear_req = 1; tick;
    clear_req = 0;
    repeat (9) tick;
    chk("busy_mid_clear", {63'd0, a_busy}, 64'd1);
    rst_n = 0;
    #1;
    chk("busy_async_reset", {62'd0, b_busy, a_busy}, 64'd0);
    tick; tick;
    rst_n = 1;
    rd(2'b11, 5'd30, 5'd2, 0, 0, 0, 0);
    tick;
    rd_en = '0;
    tick;
    clear_req = 1; tick;
    clear_req = 0;
    busy_count(n);
    chk("busy_cycles_restart", 64'(n), 64'd32);

    tick; tick;
    chk("queue_drain", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file, successor to the fixed 32x32 two-port register file in the single-cycle datapath.
- Generalises data width, depth and read-port count.
- Adds registered reads with valid flags, a hardwired zero register, and a sequential bulk-clear engine.
- Sits between decode and the ALU; the writeback stage drives the write port.

Parameters:
- DATA_W, 32, register width in bits (8..64)
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
- Clk  in  1  clock, all state changes on posedge
- Rst_n  in  1  asynchronous active-low reset
- RdEn  in  NUM_RD  per-port read enable; port p uses bit p
- RdAddr  in  NUM_RD*ADDR_W  read addresses; port p uses slice [p*ADDR_W +: ADDR_W]
- RdData  out  NUM_RD*DATA_W  registered read data; port p uses slice [p*DATA_W +: DATA_W]
- RdValid  out  NUM_RD  per-port flag: RdData slice updated at the last edge
- WrEn  in  1  write enable (equivalent of RegWrite)
- WrAddr  in  ADDR_W  write address
- WrData  in  DATA_W  write data
- ClearReq  in  1  single-cycle pulse; starts a bulk clear of all registers
- Busy  out  1  high while a clear sequence runs

Behaviour:
- Reset (Rst_n low, asynchronous):
  - all DEPTH registers = 0
  - RdData = 0, RdValid = 0, Busy = 0
  - FSM = IDLE, clear pointer = 0
  - Release is synchronous to the next posedge.
- Write: at posedge, if WrEn && !Busy, Registers[WrAddr] <= WrData.
  - If ZERO_REG=1 and WrAddr=0, the write is dropped.
  - WrEn while Busy=1 is dropped silently; there is no stall signal.
- Read, 1-cycle latency, independent per port:
  - At posedge, if RdEn[p], RdData[p] <= Registers[RdAddr[p]], using the pre-edge array contents.
  - RdValid[p] <= RdEn[p].
  - If !RdEn[p], RdData[p] holds its previous value and RdValid[p] <= 0.
  - With ZERO_REG=1, an address-0 read always yields 0.
  - Multiple ports may read the same address in the same cycle; all get identical data.
- Same-cycle write and read to the same address (non-zero, not Busy):
  - Result depends on REGFILE_BYPASS_EN (see Optional Feature).
- Clear FSM:
  - IDLE: Busy=0. ClearReq=1 -> CLEAR, pointer=0, Busy=1 from the next cycle.
  - CLEAR: each cycle Registers[pointer] <= 0, pointer++. When pointer = DEPTH-1, that entry is cleared and the FSM -> IDLE.
  - The sequence therefore takes exactly DEPTH cycles with Busy=1.
  - ClearReq while in CLEAR is ignored; there is no restart.
  - Reads during CLEAR are serviced from current array contents: already-cleared entries read 0, others read old data. No bypass is applied while Busy.
- Reset mid-clear: async clear of everything, FSM -> IDLE, Busy -> 0 immediately.
- Address arithmetic: the pointer is ADDR_W+1 bits internally, so there is no wrap ambiguity. Out-of-range addresses are impossible because depth is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined (write-first): on a same-cycle WrEn && !Busy && RdEn[p] && RdAddr[p]==WrAddr, RdData[p] captures WrData.
  - Not applied when ZERO_REG=1 and the address is 0 (result stays 0).
  - Lets writeback and decode share a cycle without a hazard stall.
- Undefined (read-first): RdData[p] captures the old register value; the new value is visible on the following read.

Test Plan:
- Reset then read: Rst_n low 3 cycles, release, RdEn=2'b11, RdAddr={5'd31,5'd7} -> one cycle later RdData={0,0}, RdValid=2'b11.
- Write/readback: write 32'hAAAAAAAA to reg 1 and 32'hBBBBBBBB to reg 2 on consecutive cycles, then read ports {1,2} -> RdData={32'hBBBBBBBB,32'hAAAAAAAA} next cycle; with RdEn=0 afterwards, data holds and RdValid=0.
- Zero register: WrEn=1, WrAddr=0, WrData=32'hDEADBEEF, then read addr 0 -> 32'h0. Repeat with ZERO_REG=0 -> 32'hDEADBEEF.
- Same-cycle hazard: reg 8 = 32'h0000000A; in one cycle write 32'h00000014 to reg 8 and read reg 8 -> 32'h00000014 with REGFILE_BYPASS_EN, 32'h0000000A without; the next read returns 32'h00000014 in both builds.
- Clear sequence: fill regs 16 and 17 with 2, pulse ClearReq -> Busy high exactly 32 cycles. A write to reg 17 during Busy is dropped. Reading reg 17 after Busy falls -> 0.
- Reset mid-clear: pulse ClearReq, assert Rst_n low at clear cycle 10 -> Busy=0 immediately, all registers read 0 after release, and a new ClearReq restarts from pointer 0.
